instruct_struct_packer: RTL and testbench

Inverse of the instruction field splitter: it takes decoded field records (format, opcode, registers, funct fields, full 32-bit immediate) and packs each into a 32-bit RV32I instruction word. It is the encoder side of the instruction-memory loader and self-test path. A start/length job controller streams the packed words, each with a word address, to the instruction-memory write port. Both the input and output sides use valid/ready handshakes, with one output register stage between them.

---
 rtl/instruct_struct_packer_pkg.sv | 38 +++
 rtl/instruct_struct_packer_if.sv | 34 +++
 rtl/instruct_struct_packer_instr_field_pack.sv | 55 +++++
 rtl/instruct_struct_packer.sv | 138 +++++++++++++
 tb/tb_instruct_struct_packer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/instruct_struct_packer_pkg.sv
// rtl/instruct_struct_packer_pkg.sv - shared format codes, opcodes, FSM states and helpers for the packer
package instruct_struct_packer_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift-immediate encodings carry funct7 in the top bits and a 5-bit shamt.
  function automatic logic is_shift(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  endfunction

  // Codes 6 and 7 do not name a format.
  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= FMT_J;
  endfunction

endpackage

// File: rtl/instruct_struct_packer_if.sv
// rtl/instruct_struct_packer_if.sv - record input and packed-word output handshake bundle
interface instruct_struct_packer_if #(
  parameter int ADDR_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );

endinterface

// File: rtl/instruct_struct_packer_instr_field_pack.sv
// rtl/instruct_struct_packer_instr_field_pack.sv - combinational field-to-word encoder; PACKER_IMM_CHECK_EN adds imm_bad
module instr_field_pack
  import instruct_struct_packer_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr
`ifdef PACKER_IMM_CHECK_EN
  ,
  output logic        imm_bad
`endif
);

  // Scatter the fields into the RV32I layout for the selected format.
  always_comb begin
    instr = '0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift(opcode, funct3)) instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else                          instr = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = '0;
    endcase
  end

`ifdef PACKER_IMM_CHECK_EN
  // Flag immediates that the chosen format cannot represent exactly.
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift(opcode, funct3)) imm_bad = (imm[31:5] != '0);
        else                          imm_bad = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_S: imm_bad = (imm != {{20{imm[11]}}, imm[11:0]});
      FMT_B: imm_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_U: imm_bad = (imm[11:0] != '0);
      FMT_J: imm_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      default: imm_bad = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/instruct_struct_packer.sv
// rtl/instruct_struct_packer.sv - job-controlled RV32I record packer; PACKER_IMM_CHECK_EN enables immediate range checks
module instruct_struct_packer
  import instruct_struct_packer_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       length,
  output logic                   busy,
  output logic                   done,
  output logic                   imm_err,
  output logic                   fmt_err,
  instruct_struct_packer_if.slave bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q;
  logic [ADDR_W-1:0] addr_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [31:0]       out_instr_q;
  logic              fmt_err_q;
  logic [31:0]       packed_word;
  logic              in_ready;
  logic              accept;
  logic              fmt_ok;
  logic              start_ok;

  assign start_ok = (state_q == IDLE) && start;
  assign fmt_ok   = fmt_legal(bus.in_fmt);
  // A held word only blocks intake when downstream is not taking it this cycle.
  assign in_ready = (state_q == RUN) && (rem_q != '0) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_instr = out_instr_q;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign fmt_err       = fmt_err_q;

`ifdef PACKER_IMM_CHECK_EN
  logic imm_bad;
  logic imm_err_q;

  instr_field_pack u_pack (
    .fmt     (bus.in_fmt),
    .opcode  (bus.in_opcode),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .funct3  (bus.in_funct3),
    .funct7  (bus.in_funct7),
    .imm     (bus.in_imm),
    .instr   (packed_word),
    .imm_bad (imm_bad)
  );

  // Sticky immediate error, cleared at the start of each job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     imm_err_q <= 1'b0;
    else if (start_ok)           imm_err_q <= 1'b0;
    else if (accept && imm_bad)  imm_err_q <= 1'b1;
  end

  assign imm_err = imm_err_q;
`else
  instr_field_pack u_pack (
    .fmt     (bus.in_fmt),
    .opcode  (bus.in_opcode),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .funct3  (bus.in_funct3),
    .funct7  (bus.in_funct7),
    .imm     (bus.in_imm),
    .instr   (packed_word)
  );

  assign imm_err = 1'b0;
`endif

  // Job state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Job sequencing: a zero-length job skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (length == '0) ? DONE : RUN;
      RUN:   if (accept && (rem_q == CNT_W'(1))) state_d = DRAIN;
      DRAIN: if (!out_valid_q || bus.out_ready) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Remaining-record count, next word address and sticky format error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      addr_q    <= BASE_ADDR;
      fmt_err_q <= 1'b0;
    end else if (start_ok) begin
      rem_q     <= length;
      addr_q    <= BASE_ADDR;
      fmt_err_q <= 1'b0;
    end else if (accept) begin
      rem_q <= rem_q - CNT_W'(1);
      if (fmt_ok) addr_q    <= addr_q + ADDR_W'(4);
      else        fmt_err_q <= 1'b1;
    end
  end

  // Output stage: load on a legal record, hold under backpressure, empty on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      out_instr_q <= '0;
    end else if (accept && fmt_ok) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= addr_q;
      out_instr_q <= packed_word;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruct_struct_packer.sv
// tb/tb_instruct_struct_packer.sv - directed self-checking bench for instruct_struct_packer
module tb_instruct_struct_packer;

  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef PACKER_IMM_CHECK_EN
  localparam logic [31:0] EXP_IMM_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_IMM_ERR = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        imm_err;
  logic        fmt_err;

  int total = 0;
  int fails = 0;

  instruct_struct_packer_if #(.ADDR_W(32)) bus ();

  instruct_struct_packer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .length  (length),
    .busy    (busy),
    .done    (done),
    .imm_err (imm_err),
    .fmt_err (fmt_err),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = fmt;
    bus.in_opcode = opc;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  // Clock one edge with a record presented, then expect it in the output stage.
  task automatic push_check(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_addr);
    step();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.out_instr, exp_instr);
    check({tag, "_addr"},  bus.out_addr,  exp_addr);
  endtask

  task automatic begin_job(input logic [15:0] len);
    start  = 1'b1;
    length = len;
    step();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    length = '0;
    bus.out_ready = 1'b1;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b0;
    step();
    step();

    // Reset values
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_addr",  bus.out_addr,       BASE);
    check("rst_out_instr", bus.out_instr,      32'd0);
    check("rst_imm_err",   32'(imm_err),       32'd0);
    check("rst_fmt_err",   32'(fmt_err),       32'd0);
    rst = 1'b0;
    step();

    // Single addi x1,x0,5
    begin_job(16'd1);
    check("j1_busy",     32'(busy),         32'd1);
    check("j1_in_ready", 32'(bus.in_ready), 32'd1);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    push_check("j1_w0", 32'h0050_0093, BASE);
    check("j1_in_ready_after", 32'(bus.in_ready), 32'd0);
    check("j1_done_early",     32'(done),         32'd0);
    step();
    check("j1_done",      32'(done),          32'd1);
    check("j1_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("j1_done_drop", 32'(done), 32'd0);
    check("j1_idle_busy", 32'(busy), 32'd0);

    // Five records back to back with out_ready high
    begin_job(16'd5);
    check("j2_rdy0", 32'(bus.in_ready), 32'd1);
    drive(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    push_check("j2_sw", 32'h0020_A423, BASE + 32'd0);
    check("j2_rdy1", 32'(bus.in_ready), 32'd1);
    drive(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    push_check("j2_beq", 32'hFE00_0EE3, BASE + 32'd4);
    check("j2_rdy2", 32'(bus.in_ready), 32'd1);
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    push_check("j2_jal", 32'h0080_00EF, BASE + 32'd8);
    check("j2_rdy3", 32'(bus.in_ready), 32'd1);
    drive(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    push_check("j2_lui", 32'h1234_52B7, BASE + 32'd12);
    check("j2_rdy4", 32'(bus.in_ready), 32'd1);
    drive(3'd1, 7'b0010011, 5'd3, 5'd3, 5'd0, 3'd1, 7'd0, 32'd7);
    push_check("j2_slli", 32'h0071_9193, BASE + 32'd16);
    step();
    check("j2_done", 32'(done), 32'd1);
    step();

    // Backpressure: first word held for 3 cycles, a stray start is ignored
    bus.out_ready = 1'b0;
    begin_job(16'd2);
    drive(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    push_check("j3_sub", 32'h4020_81B3, BASE);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    start = 1'b1;
    length = 16'd9;
    for (int k = 0; k < 3; k++) begin
      step();
      start = 1'b0;
      check("j3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("j3_hold_instr", bus.out_instr,      32'h4020_81B3);
      check("j3_hold_addr",  bus.out_addr,       BASE);
      check("j3_hold_rdy",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    push_check("j3_addi", 32'h0050_0093, BASE + 32'd4);
    step();
    check("j3_done", 32'(done), 32'd1);
    step();

    // Illegal format in the middle of a 3-record job
    begin_job(16'd3);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    push_check("j4_w0", 32'h0050_0093, BASE);
    drive(3'd7, 7'b0110011, 5'd9, 5'd9, 5'd9, 3'd0, 7'd0, 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("j4_skip_valid", 32'(bus.out_valid), 32'd0);
    check("j4_fmt_err",    32'(fmt_err),       32'd1);
    drive(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    push_check("j4_w1", 32'h1234_52B7, BASE + 32'd4);
    step();
    check("j4_done",        32'(done),    32'd1);
    check("j4_fmt_sticky",  32'(fmt_err), 32'd1);
    step();

    // Out-of-range immediates still produce truncated words
    begin_job(16'd2);
    check("j5_fmt_clr", 32'(fmt_err), 32'd0);
    drive(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    push_check("j5_b3", 32'h0000_0163, BASE);
    check("j5_imm_err_b", 32'(imm_err), EXP_IMM_ERR);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    push_check("j5_i4096", 32'h0000_0093, BASE + 32'd4);
    check("j5_imm_err_i", 32'(imm_err), EXP_IMM_ERR);
    step();
    check("j5_done", 32'(done), 32'd1);
    step();

    // Zero-length job
    begin_job(16'd0);
    check("j6_done",     32'(done),         32'd1);
    check("j6_in_ready", 32'(bus.in_ready), 32'd0);
    check("j6_busy",     32'(busy),         32'd0);
    step();
    check("j6_done_once", 32'(done),         32'd0);
    check("j6_in_ready2", 32'(bus.in_ready), 32'd0);

    // Asynchronous reset mid-job drops the pending word
    bus.out_ready = 1'b0;
    begin_job(16'd3);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    push_check("j7_w0", 32'h0050_0093, BASE);
    rst = 1'b1;
    #1;
    check("j7_rst_valid", 32'(bus.out_valid), 32'd0);
    check("j7_rst_busy",  32'(busy),          32'd0);
    check("j7_rst_instr", bus.out_instr,      32'd0);
    step();
    rst = 1'b0;
    step();
    check("j7_idle_rdy",  32'(bus.in_ready), 32'd0);
    check("j7_idle_busy", 32'(busy),         32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
